// File: rtl/btn_pkg.sv
// Shared types and width helpers for the push-button debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } btn_state_t;

  // Stability counter width; STABLE_TICKS is limited to 15.
  localparam int STAB_W = 4;

  // Bits needed to count 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    if ($clog2(max_val + 1) < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Bundle between the tick source / raw buttons and the debouncer outputs.
interface btn_debounce_if #(
  parameter int NUM_BTN = 4
);
  // db_tick is a one-cycle qualifier with no backpressure: every cycle it is
  // high counts as one sample; outputs are 1-cycle pulses with no ready.
  logic                   db_tick;
  logic [NUM_BTN-1:0]     btn_raw;
  logic [NUM_BTN-1:0]     btn_level;
  logic [NUM_BTN-1:0]     btn_press;
  logic [NUM_BTN-1:0]     btn_release;
  logic [NUM_BTN-1:0]     btn_long;
  logic [NUM_BTN-1:0]     btn_repeat;
  logic [2*NUM_BTN-1:0]   dbg_state;

  modport master (
    output db_tick, btn_raw,
    input  btn_level, btn_press, btn_release, btn_long, btn_repeat, dbg_state
  );

  modport slave (
    input  db_tick, btn_raw,
    output btn_level, btn_press, btn_release, btn_long, btn_repeat, dbg_state
  );
endinterface

// File: rtl/btn_fsm.sv
// One button: 2-flop synchronizer, tick-driven debounce FSM, hold/repeat counters.
module btn_fsm
  import btn_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 40,
  parameter int REPEAT_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       raw_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic       repeat_o,
  output btn_state_t state_o
);

  localparam int HOLD_W = cnt_w(LONG_TICKS);
  localparam int REP_W  = cnt_w(REPEAT_TICKS);
  localparam logic [STAB_W-1:0] STAB_LIM = STAB_W'(STABLE_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(LONG_TICKS);
  localparam logic [REP_W-1:0]  REP_LIM  = REP_W'(REPEAT_TICKS);

  logic              sync1_q, sync_q;
  btn_state_t        state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d, stab_inc;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [REP_W-1:0]  rep_q, rep_d, rep_inc;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;

  assign stab_inc = stab_q + STAB_W'(1);
  assign hold_inc = hold_q + HOLD_W'(1);
  assign rep_inc  = rep_q + REP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stab_q    <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      stab_q    <= stab_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stab_d    = stab_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    if (tick_i) begin
      unique case (state_q)
        IDLE: begin
          if (sync_q) begin
            state_d = ARMING;
            stab_d  = STAB_W'(1);
          end
        end
        ARMING: begin
          if (!sync_q) begin
            state_d = IDLE;
            stab_d  = '0;
          end else if (stab_inc == STAB_LIM) begin
            state_d = HELD;
            stab_d  = '0;
            hold_d  = '0;
            rep_d   = '0;
            press_d = 1'b1;
          end else begin
            stab_d = stab_inc;
          end
        end
        HELD: begin
          if (!sync_q) begin
            state_d = RELEASING;
            stab_d  = STAB_W'(1);
          end else if (hold_q != HOLD_LIM) begin
            hold_d = hold_inc;
            if (hold_inc == HOLD_LIM) begin
              long_d = 1'b1;
              rep_d  = '0;
            end
          end else if (REPEAT_TICKS > 0) begin
            // Saturated hold means long has fired; only repeat counting remains.
            if (rep_inc == REP_LIM) begin
              repeat_d = 1'b1;
              rep_d    = '0;
            end else begin
              rep_d = rep_inc;
            end
          end
        end
        RELEASING: begin
          if (sync_q) begin
            state_d = HELD;
            stab_d  = '0;
          end else if (stab_inc == STAB_LIM) begin
            state_d   = IDLE;
            stab_d    = '0;
            release_d = 1'b1;
          end else begin
            stab_d = stab_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    level_d = (state_d == HELD) || (state_d == RELEASING);
  end

  always_comb begin
    level_o   = level_q;
    press_o   = press_q;
    release_o = release_q;
    long_o    = long_q;
    repeat_o  = repeat_q;
    state_o   = state_q;
  end

endmodule

// File: rtl/btn_debounce.sv
// Debouncer top: one btn_fsm per button, outputs gathered onto the bus.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int NUM_BTN      = 4,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 40,
  parameter int REPEAT_TICKS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  btn_debounce_if.slave  bus
);

  logic [NUM_BTN-1:0]   level_v;
  logic [NUM_BTN-1:0]   press_v;
  logic [NUM_BTN-1:0]   release_v;
  logic [NUM_BTN-1:0]   long_v;
  logic [NUM_BTN-1:0]   repeat_v;
  logic [2*NUM_BTN-1:0] state_v;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_state_t st;

    btn_fsm #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (bus.db_tick),
      .raw_i     (bus.btn_raw[g]),
      .level_o   (level_v[g]),
      .press_o   (press_v[g]),
      .release_o (release_v[g]),
      .long_o    (long_v[g]),
      .repeat_o  (repeat_v[g]),
      .state_o   (st)
    );

    assign state_v[2*g +: 2] = st;
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;
  assign bus.btn_long    = long_v;
  assign bus.btn_repeat  = repeat_v;
  assign bus.dbg_state   = state_v;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: table-driven level checks plus a timed pulse scoreboard.
module tb_btn_debounce;

  localparam int NB = 2;
  localparam int W  = 20;
  localparam logic [2:0] EV_PRESS = 3'd1;
  localparam logic [2:0] EV_REL   = 3'd2;
  localparam logic [2:0] EV_LONG  = 3'd3;
  localparam logic [2:0] EV_REP   = 3'd4;

  typedef struct {
    logic [1:0] raw;
    int         ticks;
    logic [1:0] lvl;
    logic [2:0] ev;
    logic [1:0] ev_mask;
    int         ev_off;
  } vec_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic tick_en = 1'b1;
  int   cyc     = 0;
  int   tick_cnt = 0;
  int   n_vec   = 0;
  int   n_err   = 0;
  logic [W-1:0] exp_q[$];

  btn_debounce_if #(.NUM_BTN(NB)) bus ();

  btn_debounce #(
    .NUM_BTN      (NB),
    .STABLE_TICKS (4),
    .LONG_TICKS   (40),
    .REPEAT_TICKS (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  initial begin
    bus.db_tick = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.db_tick = tick_en && (cyc % 10 == 0);
    end
  end

  // ---------------- scoreboard ----------------
  function automatic logic [W-1:0] mk_ev(logic [2:0] t, int b, int tk);
    return {t, 1'(b), 16'(tk)};
  endfunction

  task automatic push_ev(logic [2:0] t, int b, int tk);
    exp_q.push_back(mk_ev(t, b, tk));
  endtask

  task automatic check_ev(logic [2:0] t, logic [NB-1:0] v);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    for (int b = 0; b < NB; b++) begin
      if (v[b]) begin
        got = mk_ev(t, b, tick_cnt);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL event: unexpected type %0d btn %0d at tick %0d", t, b, tick_cnt);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL event: got type %0d btn %0d tick %0d, expected type %0d btn %0d tick %0d",
                     got[19:17], got[16], got[15:0], exp[19:17], exp[16], exp[15:0]);
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.db_tick) tick_cnt++;
      check_ev(EV_PRESS, bus.btn_press);
      check_ev(EV_REL,   bus.btn_release);
      check_ev(EV_LONG,  bus.btn_long);
      check_ev(EV_REP,   bus.btn_repeat);
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all_zero(string name);
    check(name, {22'd0, bus.btn_level, bus.btn_press, bus.btn_release,
                 bus.btn_long, bus.btn_repeat}, 32'd0);
    check({name, "_state"}, {28'd0, bus.dbg_state}, 32'd0);
  endtask

  task automatic wait_until(int target);
    int guard = 0;
    while (tick_cnt < target && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (tick_cnt < target) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_until: tick %0d never reached, at %0d", target, tick_cnt);
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t vt[13];
  int   base;

  initial begin
    vt[0]  = '{2'b01, 14, 2'b01, EV_PRESS, 2'b01, 4};
    vt[1]  = '{2'b00,  6, 2'b00, EV_REL,   2'b01, 4};
    vt[2]  = '{2'b11,  6, 2'b11, EV_PRESS, 2'b11, 4};
    vt[3]  = '{2'b10,  6, 2'b10, EV_REL,   2'b01, 4};
    vt[4]  = '{2'b00,  6, 2'b00, EV_REL,   2'b10, 4};
    vt[5]  = '{2'b01,  2, 2'b00, 3'd0,     2'b00, 0};
    vt[6]  = '{2'b00,  6, 2'b00, 3'd0,     2'b00, 0};
    vt[7]  = '{2'b01,  3, 2'b00, 3'd0,     2'b00, 0};
    vt[8]  = '{2'b00,  2, 2'b00, 3'd0,     2'b00, 0};
    vt[9]  = '{2'b01,  4, 2'b01, EV_PRESS, 2'b01, 4};
    vt[10] = '{2'b00,  3, 2'b01, 3'd0,     2'b00, 0};
    vt[11] = '{2'b01,  2, 2'b01, 3'd0,     2'b00, 0};
    vt[12] = '{2'b00,  4, 2'b00, EV_REL,   2'b01, 4};

    bus.btn_raw = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // ticks off: raw activity must never reach the outputs
    @(posedge clk);
    #2 tick_en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check_all_zero("no_tick");
      bus.btn_raw = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    bus.btn_raw = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 tick_en = 1'b1;
    wait_until(tick_cnt + 1);

    // table-driven level checks with timed events
    for (int i = 0; i < 13; i++) begin
      base = tick_cnt;
      bus.btn_raw = vt[i].raw;
      for (int b = 0; b < NB; b++)
        if (vt[i].ev_mask[b]) push_ev(vt[i].ev, b, base + vt[i].ev_off);
      wait_until(base + vt[i].ticks);
      check($sformatf("vec%0d_level", i), {30'd0, bus.btn_level}, {30'd0, vt[i].lvl});
    end

    // bounce on btn0: toggles every 7 cycles, then settles high
    base = tick_cnt;
    bus.btn_raw = 2'b01;
    push_ev(EV_PRESS, 0, base + 8);
    for (int k = 0; k < 7; k++) begin
      repeat (7) @(negedge clk);
      bus.btn_raw[0] = ~bus.btn_raw[0];
      check("bounce_level", {30'd0, bus.btn_level}, 32'd0);
    end
    @(negedge clk);
    bus.btn_raw[0] = 1'b1;
    wait_until(base + 8);
    check("bounce_pressed", {30'd0, bus.btn_level}, 32'd1);
    base = tick_cnt;
    bus.btn_raw = 2'b00;
    push_ev(EV_REL, 0, base + 4);
    wait_until(base + 6);
    check("bounce_released", {30'd0, bus.btn_level}, 32'd0);

    // long hold on btn1: long at hold tick 40, repeats at 48/56/64
    base = tick_cnt;
    bus.btn_raw = 2'b10;
    push_ev(EV_PRESS, 1, base + 4);
    push_ev(EV_LONG,  1, base + 44);
    push_ev(EV_REP,   1, base + 52);
    push_ev(EV_REP,   1, base + 60);
    push_ev(EV_REP,   1, base + 68);
    wait_until(base + 74);
    check("hold_level", {30'd0, bus.btn_level}, 32'd2);
    bus.btn_raw = 2'b00;
    push_ev(EV_REL, 1, base + 78);
    wait_until(base + 80);
    check("hold_released", {30'd0, bus.btn_level}, 32'd0);

    // 2-tick glitch at hold tick 20 delays long by the frozen ticks
    base = tick_cnt;
    bus.btn_raw = 2'b01;
    push_ev(EV_PRESS, 0, base + 4);
    wait_until(base + 24);
    bus.btn_raw = 2'b00;
    wait_until(base + 26);
    check("glitch_level", {30'd0, bus.btn_level}, 32'd1);
    bus.btn_raw = 2'b01;
    push_ev(EV_LONG, 0, base + 47);
    wait_until(base + 50);
    bus.btn_raw = 2'b00;
    push_ev(EV_REL, 0, base + 54);
    wait_until(base + 56);
    check("glitch_released", {30'd0, bus.btn_level}, 32'd0);

    // async reset in ARMING, then a fresh press
    base = tick_cnt;
    bus.btn_raw = 2'b01;
    wait_until(base + 2);
    #3 rst_n = 1'b0;
    #1 check_all_zero("rst_arming");
    wait_until(tick_cnt + 1);
    #3 rst_n = 1'b1;
    @(negedge clk);
    base = tick_cnt;
    push_ev(EV_PRESS, 0, base + 4);
    wait_until(base + 4);
    check("rst_arming_repress", {30'd0, bus.btn_level}, 32'd1);

    // async reset in HELD, then a fresh press and release
    wait_until(base + 10);
    #3 rst_n = 1'b0;
    #1 check_all_zero("rst_held");
    wait_until(tick_cnt + 1);
    #3 rst_n = 1'b1;
    @(negedge clk);
    base = tick_cnt;
    push_ev(EV_PRESS, 0, base + 4);
    wait_until(base + 4);
    check("rst_held_repress", {30'd0, bus.btn_level}, 32'd1);
    bus.btn_raw = 2'b00;
    push_ev(EV_REL, 0, base + 8);
    wait_until(base + 10);
    check("rst_held_released", {30'd0, bus.btn_level}, 32'd0);

    // ---------------- report ----------------
    repeat (5) @(negedge clk);
    check("events_outstanding", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL timeout: bench did not complete at tick %0d", tick_cnt);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Consumer end of the divider's tick interface: takes the 25 ms single-cycle debounce tick, plus raw push-button inputs.
- Per button, produces a clean level and single-cycle press, release, long-press and auto-repeat pulses.
- Sits between board buttons and the control FSMs (stopwatch start/stop, mode, set).
- All timing is counted in ticks, so the block has no dependence on the clock frequency.

Parameters:
- NUM_BTN, 4, number of independent buttons.
- STABLE_TICKS, 4, consecutive agreeing tick samples needed to accept a change; legal range 2..15.
- LONG_TICKS, 40, ticks held after the press pulse before the long pulse (40 x 25 ms = 1 s); must be at least 1.
- REPEAT_TICKS, 8, ticks between repeat pulses after the long pulse; 0 disables repeat.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- db_tick  in  1  single-cycle enable pulse from the clock divider, every 25 ms.
- btn_raw  in  NUM_BTN  asynchronous active-high buttons.
- btn_level  out  NUM_BTN  debounced level.
- btn_press  out  NUM_BTN  1-cycle pulse on accepted press.
- btn_release  out  NUM_BTN  1-cycle pulse on accepted release.
- btn_long  out  NUM_BTN  1-cycle pulse when held LONG_TICKS.
- btn_repeat  out  NUM_BTN  1-cycle pulse every REPEAT_TICKS after long.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. Asserting it clears everything immediately, mid-operation included:
  - all sync flops, counters and outputs go to 0;
  - all FSMs go to IDLE.
- Each btn_raw bit passes through a 2-flop synchronizer (sync). The FSM samples sync only on cycles where db_tick=1; with db_tick=0, state and counters hold.
- Per-button FSM states, with stab = stability count (4 bits) and hold = hold count (saturating):
  - IDLE (level 0): on tick with sync=1, go to ARMING with stab=1.
  - ARMING (level 0):
    - tick with sync=1: stab+1; if stab+1==STABLE_TICKS, go to HELD, clear hold and rep, pulse press.
    - tick with sync=0: go to IDLE, stab=0.
  - HELD (level 1):
    - tick with sync=1: hold+1, saturating at LONG_TICKS. On the tick where hold reaches LONG_TICKS, pulse long and clear rep.
    - After that, with REPEAT_TICKS>0: each tick increments rep; when rep reaches REPEAT_TICKS, pulse repeat and set rep to 0.
    - tick with sync=0: go to RELEASING, stab=1; hold and rep freeze.
  - RELEASING (level 1):
    - tick with sync=0: stab+1; at STABLE_TICKS go to IDLE and pulse release.
    - tick with sync=1: go back to HELD, stab=0; hold and rep resume from their frozen values. No second press pulse.
- All outputs are registered. A pulse is high for exactly the one clk cycle after the deciding tick cycle. btn_level changes in that same cycle.
- Latency from a clean raw edge to the press pulse: 2 sync cycles plus STABLE_TICKS tick samples, then 1 cycle.
- Long pulses at most once per press. Repeat pulses only while in HELD and after long. No pulses in IDLE or ARMING.
- Buttons are fully independent. Simultaneous events on different buttons all pulse in the same cycle.
- db_tick held high for consecutive cycles counts each cycle as a tick; the block does not detect or filter this.
- Counter widths: hold is $clog2(LONG_TICKS+1) bits; rep is $clog2(REPEAT_TICKS+1) bits, minimum 1. No wrap-around is possible.

Decomposition:
- Package btn_pkg holds:
  - the state typedef (IDLE, ARMING, HELD, RELEASING; 2 bits);
  - localparam width helpers for the stab, hold and rep counters.
- Sub-module btn_fsm covers one button: synchronizer, FSM and counters, with 1-bit outputs.
- btn_debounce instantiates NUM_BTN copies of btn_fsm with a generate loop and concatenates their outputs.

Test Plan (NUM_BTN=2, STABLE_TICKS=4, LONG_TICKS=40, REPEAT_TICKS=8, bench db_tick every 10 cycles):
- Clean press of btn0, held 10 ticks, then clean release:
  - btn_press[0] pulses once, 4 tick samples after sync goes high; btn_level[0]=1 from the same cycle;
  - btn_release[0] pulses once after 4 zero samples; no long pulse.
- Bounce: btn0 toggles every 7 cycles for 50 cycles, then stays high:
  - no pulses during bouncing;
  - exactly one press pulse after 4 stable high ticks.
- Hold btn1 for 70 ticks after press:
  - btn_long[1] on hold tick 40;
  - btn_repeat[1] at ticks 48, 56, 64 (3 pulses);
  - release gives one release pulse.
- Glitch during hold: btn0 goes low for 2 ticks at hold tick 20, then high again:
  - no release or press pulse;
  - long pulse at hold tick 40; frozen ticks are not counted.
- Assert rst_n=0 mid-ARMING and mid-HELD, asynchronously and off a clock edge:
  - all outputs 0 immediately;
  - after release with the button still high, a fresh press pulse after 4 ticks.
- db_tick tied low while btn_raw toggles for 1000 cycles: every output stays 0.
